// File: rtl/multicycle_control_fsm.sv
// Multi-cycle RV32I control FSM: sequences fetch/decode/execute/memory/writeback
// and times out stalled memory accesses. Define MCU_PERF_CNT_EN for cycle/instret counters.
module multicycle_control_fsm #(
    parameter int MEM_TIMEOUT = 16,
    parameter int TO_W        = 8
`ifdef MCU_PERF_CNT_EN
    ,
    parameter int CNT_W       = 32
`endif
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] opcode,
    input  logic       mem_ready,
    input  logic       branch_taken,
    output logic       pc_write,
    output logic       ir_write,
    output logic       branch,
    output logic       mem_read,
    output logic       mem_write,
    output logic       iord,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] result_src,
    output logic       reg_write,
    output logic       illegal_instr,
    output logic       mem_error,
    output logic       retired
`ifdef MCU_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instret_cnt
`endif
);

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;

    typedef enum logic [3:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXEC_R, S_EXEC_I, S_ALU_WB, S_MEM_ADDR,
        S_MEM_RD, S_MEM_WB, S_MEM_WR, S_BRANCH, S_JAL, S_LUI, S_HALT
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [TO_W-1:0] to_cnt;
    logic            mem_wait;
    logic            to_hit;
    logic            timeout;

    // The branch decision is applied by the datapath, not by this FSM.
    logic unused_branch_taken;
    assign unused_branch_taken = branch_taken;

    assign mem_wait = (state == S_FETCH) || (state == S_MEM_RD) || (state == S_MEM_WR);
    // to_cnt holds completed wait cycles, so the limit is hit on the MEM_TIMEOUT-th wait.
    assign to_hit   = (to_cnt == TO_W'(MEM_TIMEOUT - 1));
    assign timeout  = mem_wait && !mem_ready && to_hit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            to_cnt    <= '0;
            mem_error <= 1'b0;
        end else begin
            state <= state_next;
            if (mem_wait && !mem_ready && !timeout)
                to_cnt <= to_cnt + TO_W'(1);
            else
                to_cnt <= '0;
            if (timeout)
                mem_error <= 1'b1;
        end
    end

    always_comb begin
        state_next    = state;
        pc_write      = 1'b0;
        ir_write      = 1'b0;
        branch        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        iord          = 1'b0;
        alu_src_a     = 2'b00;
        alu_src_b     = 2'b00;
        alu_op        = 2'b00;
        result_src    = 2'b00;
        reg_write     = 1'b0;
        illegal_instr = 1'b0;
        retired       = 1'b0;
        case (state)
            S_IDLE: state_next = S_FETCH;
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b10;
                if (mem_ready) begin
                    ir_write   = 1'b1;
                    pc_write   = 1'b1;
                    state_next = S_DECODE;
                end else if (to_hit) begin
                    state_next = S_HALT;
                end
            end
            S_DECODE: begin
                case (opcode)
                    OP_R:               state_next = S_EXEC_R;
                    OP_I:               state_next = S_EXEC_I;
                    OP_LOAD, OP_STORE:  state_next = S_MEM_ADDR;
                    OP_BR:              state_next = S_BRANCH;
                    OP_JAL:             state_next = S_JAL;
                    OP_LUI:             state_next = S_LUI;
                    default: begin
                        illegal_instr = 1'b1;
                        state_next    = S_FETCH;
                    end
                endcase
            end
            S_EXEC_R: begin
                alu_src_a  = 2'b01;
                alu_op     = 2'b10;
                state_next = S_ALU_WB;
            end
            S_EXEC_I: begin
                alu_src_a  = 2'b01;
                alu_src_b  = 2'b01;
                alu_op     = 2'b11;
                state_next = S_ALU_WB;
            end
            S_ALU_WB: begin
                reg_write  = 1'b1;
                retired    = 1'b1;
                state_next = S_FETCH;
            end
            S_MEM_ADDR: begin
                alu_src_a  = 2'b01;
                alu_src_b  = 2'b01;
                state_next = (opcode == OP_LOAD) ? S_MEM_RD : S_MEM_WR;
            end
            S_MEM_RD: begin
                mem_read = 1'b1;
                iord     = 1'b1;
                if (mem_ready)
                    state_next = S_MEM_WB;
                else if (to_hit)
                    state_next = S_HALT;
            end
            S_MEM_WB: begin
                reg_write  = 1'b1;
                result_src = 2'b01;
                retired    = 1'b1;
                state_next = S_FETCH;
            end
            S_MEM_WR: begin
                mem_write = 1'b1;
                iord      = 1'b1;
                if (mem_ready) begin
                    retired    = 1'b1;
                    state_next = S_FETCH;
                end else if (to_hit) begin
                    state_next = S_HALT;
                end
            end
            S_BRANCH: begin
                branch     = 1'b1;
                alu_src_a  = 2'b01;
                alu_op     = 2'b01;
                retired    = 1'b1;
                state_next = S_FETCH;
            end
            S_JAL: begin
                pc_write   = 1'b1;
                reg_write  = 1'b1;
                result_src = 2'b10;
                retired    = 1'b1;
                state_next = S_FETCH;
            end
            S_LUI: begin
                alu_src_a  = 2'b10;
                alu_src_b  = 2'b01;
                state_next = S_ALU_WB;
            end
            S_HALT:  state_next = S_HALT;
            default: state_next = S_IDLE;
        endcase
    end

`ifdef MCU_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycle_cnt   <= '0;
            instret_cnt <= '0;
        end else begin
            if (state != S_IDLE && state != S_HALT)
                cycle_cnt <= cycle_cnt + CNT_W'(1);
            if (retired)
                instret_cnt <= instret_cnt + CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed bench for multicycle_control_fsm: walks each instruction class, the
// memory timeout boundary and asynchronous reset, comparing all outputs per cycle.
module tb_multicycle_control_fsm;

    logic       clk;
    logic       rst_n;
    logic [6:0] opcode;
    logic       mem_ready;
    logic       branch_taken;
    logic       pc_write, ir_write, branch, mem_read, mem_write, iord;
    logic [1:0] alu_src_a, alu_src_b, alu_op, result_src;
    logic       reg_write, illegal_instr, mem_error, retired;
`ifdef MCU_PERF_CNT_EN
    logic [31:0] cycle_cnt, instret_cnt;
`endif

    int n_vec = 0;
    int n_err = 0;

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_LD  = 7'b0000011;
    localparam logic [6:0] OP_ST  = 7'b0100011;
    localparam logic [6:0] OP_BR  = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_LUI = 7'b0110111;
    localparam logic [6:0] OP_BAD = 7'b1111111;

    multicycle_control_fsm #(.MEM_TIMEOUT(16), .TO_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
        .branch_taken(branch_taken), .pc_write(pc_write), .ir_write(ir_write),
        .branch(branch), .mem_read(mem_read), .mem_write(mem_write), .iord(iord),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .result_src(result_src), .reg_write(reg_write), .illegal_instr(illegal_instr),
        .mem_error(mem_error), .retired(retired)
`ifdef MCU_PERF_CNT_EN
        , .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
`endif
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [17:0] obs;
    assign obs = {pc_write, ir_write, branch, mem_read, mem_write, iord,
                  alu_src_a, alu_src_b, alu_op, result_src,
                  reg_write, illegal_instr, mem_error, retired};

    function automatic logic [17:0] ov(input logic pcw, input logic irw, input logic br,
                                       input logic mr, input logic mw, input logic io,
                                       input logic [1:0] sa, input logic [1:0] sb,
                                       input logic [1:0] op, input logic [1:0] rs,
                                       input logic rw, input logic ill,
                                       input logic err, input logic ret);
        return {pcw, irw, br, mr, mw, io, sa, sb, op, rs, rw, ill, err, ret};
    endfunction

    logic [17:0] e_z, e_fw, e_fd, e_r, e_i, e_awb, e_ma, e_rd, e_mwb;
    logic [17:0] e_wrw, e_wrd, e_br, e_jal, e_lui, e_ill, e_halt;

    task automatic chk(input string tag, input logic [17:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %b want %b", tag, obs, exp);
        end
    endtask

    // driver: apply inputs at the falling edge, check settled outputs 1ns later
    task automatic cyc(input logic [6:0] op, input logic rdy, input string tag,
                       input logic [17:0] exp);
        @(negedge clk);
        opcode    = op;
        mem_ready = rdy;
        #1;
        chk(tag, exp);
    endtask

    initial begin
        e_z    = '0;
        e_fw   = ov(0,0,0,1,0,0,2'b00,2'b10,2'b00,2'b00,0,0,0,0);
        e_fd   = ov(1,1,0,1,0,0,2'b00,2'b10,2'b00,2'b00,0,0,0,0);
        e_r    = ov(0,0,0,0,0,0,2'b01,2'b00,2'b10,2'b00,0,0,0,0);
        e_i    = ov(0,0,0,0,0,0,2'b01,2'b01,2'b11,2'b00,0,0,0,0);
        e_awb  = ov(0,0,0,0,0,0,2'b00,2'b00,2'b00,2'b00,1,0,0,1);
        e_ma   = ov(0,0,0,0,0,0,2'b01,2'b01,2'b00,2'b00,0,0,0,0);
        e_rd   = ov(0,0,0,1,0,1,2'b00,2'b00,2'b00,2'b00,0,0,0,0);
        e_mwb  = ov(0,0,0,0,0,0,2'b00,2'b00,2'b00,2'b01,1,0,0,1);
        e_wrw  = ov(0,0,0,0,1,1,2'b00,2'b00,2'b00,2'b00,0,0,0,0);
        e_wrd  = ov(0,0,0,0,1,1,2'b00,2'b00,2'b00,2'b00,0,0,0,1);
        e_br   = ov(0,0,1,0,0,0,2'b01,2'b00,2'b01,2'b00,0,0,0,1);
        e_jal  = ov(1,0,0,0,0,0,2'b00,2'b00,2'b00,2'b10,1,0,0,1);
        e_lui  = ov(0,0,0,0,0,0,2'b10,2'b01,2'b00,2'b00,0,0,0,0);
        e_ill  = ov(0,0,0,0,0,0,2'b00,2'b00,2'b00,2'b00,0,1,0,0);
        e_halt = ov(0,0,0,0,0,0,2'b00,2'b00,2'b00,2'b00,0,0,1,0);

        rst_n        = 1'b0;
        opcode       = '0;
        mem_ready    = 1'b0;
        branch_taken = 1'b0;
        repeat (2) @(negedge clk);
        #1 chk("reset", e_z);
        @(negedge clk);
        rst_n = 1'b1;
        #1 chk("idle", e_z);

        // R-type, memory ready immediately
        cyc(OP_R, 1'b1, "r_fetch",  e_fd);
        cyc(OP_R, 1'b0, "r_decode", e_z);
        cyc(OP_R, 1'b0, "r_exec",   e_r);
        cyc(OP_R, 1'b0, "r_wb",     e_awb);

        // load with a 3-cycle MEM_RD
        cyc(OP_LD, 1'b1, "ld_fetch",  e_fd);
        cyc(OP_LD, 1'b0, "ld_decode", e_z);
        cyc(OP_LD, 1'b0, "ld_addr",   e_ma);
        cyc(OP_LD, 1'b0, "ld_rd1",    e_rd);
        cyc(OP_LD, 1'b0, "ld_rd2",    e_rd);
        cyc(OP_LD, 1'b1, "ld_rd3",    e_rd);
        cyc(OP_LD, 1'b0, "ld_wb",     e_mwb);

        // store then branch, memory ready immediately
        cyc(OP_ST, 1'b1, "st_fetch",  e_fd);
        cyc(OP_ST, 1'b0, "st_decode", e_z);
        cyc(OP_ST, 1'b0, "st_addr",   e_ma);
        cyc(OP_ST, 1'b1, "st_wr",     e_wrd);
        branch_taken = 1'b1;
        cyc(OP_BR, 1'b1, "br_fetch",  e_fd);
        cyc(OP_BR, 1'b0, "br_decode", e_z);
        cyc(OP_BR, 1'b0, "br_exec",   e_br);
        branch_taken = 1'b0;

        // illegal opcode returns to FETCH without retiring
        cyc(OP_BAD, 1'b1, "ill_fetch",   e_fd);
        cyc(OP_BAD, 1'b0, "ill_decode",  e_ill);
        cyc(OP_BAD, 1'b0, "ill_refetch", e_fw);
        cyc(OP_I,   1'b1, "i_fetch",     e_fd);
        cyc(OP_I,   1'b0, "i_decode",    e_z);
        cyc(OP_I,   1'b0, "i_exec",      e_i);
        cyc(OP_I,   1'b0, "i_wb",        e_awb);

        cyc(OP_LUI, 1'b1, "lui_fetch",  e_fd);
        cyc(OP_LUI, 1'b0, "lui_decode", e_z);
        cyc(OP_LUI, 1'b0, "lui_exec",   e_lui);
        cyc(OP_LUI, 1'b0, "lui_wb",     e_awb);

        // ready arrives on the 16th fetch cycle: no error
        for (int i = 1; i <= 15; i++)
            cyc(OP_JAL, 1'b0, "to_edge_wait", e_fw);
        cyc(OP_JAL, 1'b1, "to_edge_done",   e_fd);
        cyc(OP_JAL, 1'b0, "jal_decode",     e_z);
        cyc(OP_JAL, 1'b0, "jal_exec",       e_jal);

        // ready never arrives: HALT with sticky mem_error after 16 waits
        for (int i = 1; i <= 16; i++)
            cyc(OP_R, 1'b0, "to_wait", e_fw);
        cyc(OP_R, 1'b0, "halt",       e_halt);
        cyc(OP_R, 1'b1, "halt_stay1", e_halt);
        cyc(OP_R, 1'b1, "halt_stay2", e_halt);

        @(negedge clk);
        rst_n = 1'b0;
        #1 chk("halt_reset", e_z);
        @(negedge clk);
        rst_n = 1'b1;
        #1 chk("halt_idle", e_z);

        // reset asserted mid-store drops mem_write immediately
        cyc(OP_ST, 1'b1, "st2_fetch",   e_fd);
        cyc(OP_ST, 1'b0, "st2_decode",  e_z);
        cyc(OP_ST, 1'b0, "st2_addr",    e_ma);
        cyc(OP_ST, 1'b0, "st2_wr_wait", e_wrw);
        #2 rst_n = 1'b0;
        #1 chk("async_reset", e_z);
        @(negedge clk);
        rst_n = 1'b1;
        #1 chk("post_reset_idle", e_z);
        cyc(OP_ST, 1'b0, "post_reset_fetch", e_fw);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
